// File: rtl/sram_like_responder.sv
// sram_like_responder: slave end of the sram-like split address/data handshake.
// Issues each accepted request to a single-cycle synchronous SRAM port, buffers
// the returned word in an in-order FIFO and releases it after DELAY extra cycles.
module sram_like_responder #(
   parameter int unsigned DEPTH = 4,
   parameter int unsigned DELAY = 0
) (
   input  logic        clk,
   input  logic        resetn,
   input  logic        req,
   input  logic        wr,
   input  logic [1:0]  size,
   input  logic [3:0]  wstrb,
   input  logic [31:0] addr,
   input  logic [31:0] wdata,
   output logic        addr_ok,
   output logic        data_ok,
   output logic [31:0] rdata,
   output logic        sram_en,
   output logic [3:0]  sram_wen,
   output logic [31:0] sram_addr,
   output logic [31:0] sram_wdata,
   input  logic [31:0] sram_rdata
);

   localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int unsigned CW = PW + 1;
   localparam logic [3:0]    TIMER_INIT = 4'(DELAY);
   localparam logic [CW-1:0] DEPTH_C    = CW'(DEPTH);

   logic [PW-1:0] head;
   logic [PW-1:0] tail;
   logic [CW-1:0] fill;
   logic [CW-1:0] count;
   logic          in_flight;
   logic          in_flight_wr;
   logic          accept;
   logic          push;
   logic          pop;
   logic          size_unused;
   logic [31:0]   entry_data  [DEPTH];
   logic [3:0]    entry_timer [DEPTH];

   // Occupancy, handshake outputs and the SRAM request path
   always_comb begin
      count       = fill + CW'(in_flight);
      addr_ok     = (count < DEPTH_C);
      // Gating with resetn keeps the SRAM idle while reset is held, even with req high.
      accept      = req && addr_ok && resetn;
      push        = in_flight;
      pop         = (fill != '0) && (entry_timer[head] == 4'd0);
      data_ok     = pop;
      rdata       = pop ? entry_data[head] : '0;
      sram_en     = accept;
      sram_wen    = (accept && wr) ? wstrb : '0;
      sram_addr   = addr;
      sram_wdata  = wdata;
      size_unused = ^size;
   end

   // In-flight stage, FIFO pointers and fill level
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         head         <= '0;
         tail         <= '0;
         fill         <= '0;
         in_flight    <= 1'b0;
         in_flight_wr <= 1'b0;
      end else begin
         in_flight    <= accept;
         in_flight_wr <= accept && wr;
         if (push) tail <= tail + 1'b1;
         if (pop)  head <= head + 1'b1;
         case ({push, pop})
            2'b10:   fill <= fill + 1'b1;
            2'b01:   fill <= fill - 1'b1;
            default: fill <= fill;
         endcase
      end
   end

   for (genvar g = 0; g < DEPTH; g++) begin : g_entry
      // Per-entry data capture and countdown timer
      always_ff @(posedge clk or negedge resetn) begin
         if (!resetn) begin
            entry_data[g]  <= '0;
            entry_timer[g] <= '0;
         end else if (push && (tail == PW'(g))) begin
            entry_data[g]  <= in_flight_wr ? '0 : sram_rdata;
            entry_timer[g] <= TIMER_INIT;
         end else if (entry_timer[g] != 4'd0) begin
            entry_timer[g] <= entry_timer[g] - 4'd1;
         end
      end
   end

endmodule

// File: tb/tb_sram_like_responder.sv
// Bench for sram_like_responder: two instances (DELAY=0 and DELAY=3, DEPTH=4),
// a behavioural SRAM per instance and an in-order scoreboard per instance.
module tb_sram_like_responder;

   typedef struct packed {
      logic [31:0] data;
      int          due;
   } exp_t;

   logic        clk = 1'b0;
   logic        resetn;
   logic        req [2];
   logic        wr [2];
   logic [1:0]  size [2];
   logic [3:0]  wstrb [2];
   logic [31:0] addr [2];
   logic [31:0] wdata [2];
   logic        addr_ok [2];
   logic        data_ok [2];
   logic [31:0] rdata [2];
   logic        sram_en [2];
   logic [3:0]  sram_wen [2];
   logic [31:0] sram_addr [2];
   logic [31:0] sram_wdata [2];
   logic [31:0] sram_rdata [2];

   int n_tests = 0;
   int n_fail  = 0;
   int cyc     = 0;

   always #5 clk = ~clk;

   always @(posedge clk) cyc++;

   function automatic logic [31:0] pat(input logic [31:0] a);
      return (a == 32'h0000_1000) ? 32'hDEAD_BEEF : a;
   endfunction

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      assert (got === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   for (genvar g = 0; g < 2; g++) begin : u
      localparam int unsigned DLY = (g == 0) ? 0 : 3;
      exp_t q[$];
      int   outstanding = 0;

      sram_like_responder #(.DEPTH(4), .DELAY(DLY)) dut (
         .clk(clk), .resetn(resetn), .req(req[g]), .wr(wr[g]), .size(size[g]),
         .wstrb(wstrb[g]), .addr(addr[g]), .wdata(wdata[g]), .addr_ok(addr_ok[g]),
         .data_ok(data_ok[g]), .rdata(rdata[g]), .sram_en(sram_en[g]),
         .sram_wen(sram_wen[g]), .sram_addr(sram_addr[g]), .sram_wdata(sram_wdata[g]),
         .sram_rdata(sram_rdata[g])
      );

      // SRAM model: data valid only the cycle after an enabled access
      always @(posedge clk)
         sram_rdata[g] <= sram_en[g] ? pat(sram_addr[g]) : 32'hBADB_AD00;

      // Scoreboard and per-cycle protocol checks
      always @(negedge clk) begin
         exp_t e;
         logic acc;
         logic exp_dok;
         if (!resetn) begin
            q.delete();
            chk("rst_addr_ok", addr_ok[g], 1);
            chk("rst_data_ok", data_ok[g], 0);
            chk("rst_rdata", rdata[g], 0);
            chk("rst_sram_en", sram_en[g], 0);
            chk("rst_sram_wen", sram_wen[g], 0);
         end else begin
            acc = req[g] && addr_ok[g];
            chk("addr_ok", addr_ok[g], q.size() < 4);
            chk("sram_en", sram_en[g], acc);
            chk("sram_wen", sram_wen[g], (acc && wr[g]) ? wstrb[g] : 4'h0);
            if (acc) begin
               chk("sram_addr", sram_addr[g], addr[g]);
               chk("sram_wdata", sram_wdata[g], wdata[g]);
            end
            exp_dok = (q.size() != 0) && (q[0].due == cyc);
            chk("data_ok", data_ok[g], exp_dok);
            if (data_ok[g] && q.size() != 0) begin
               e = q.pop_front();
               chk("rdata", rdata[g], e.data);
            end else if (!data_ok[g]) begin
               chk("rdata_idle", rdata[g], 0);
            end
            if (acc) begin
               e.data = wr[g] ? 32'h0 : pat(addr[g]);
               e.due  = cyc + 2 + int'(DLY);
               q.push_back(e);
            end
         end
         outstanding = q.size();
      end
   end

   task automatic issue(input int n, input logic w, input logic [3:0] s,
                        input logic [31:0] a, input logic [31:0] d,
                        output int acc, output int waited);
      req[n] = 1'b1; wr[n] = w; wstrb[n] = s; addr[n] = a; wdata[n] = d; size[n] = 2'b10;
      waited = 0;
      @(negedge clk);
      while (!addr_ok[n] && waited < 50) begin
         waited++;
         @(negedge clk);
      end
      if (waited >= 50) chk("accept_timeout", addr_ok[n], 1);
      acc = cyc;
      @(posedge clk); #1;
      req[n] = 1'b0;
   endtask

   task automatic idle(input int n);
      repeat (n) begin @(posedge clk); #1; end
   endtask

   initial begin
      int acc [6];
      int w   [6];
      int t, k;
      for (int i = 0; i < 2; i++) begin
         req[i] = 0; wr[i] = 0; size[i] = 0; wstrb[i] = 0; addr[i] = 0; wdata[i] = 0;
      end
      resetn = 1'b1;
      #1 resetn = 1'b0;
      repeat (3) @(posedge clk);
      #3 resetn = 1'b1;
      idle(2);

      // Single read, DELAY=0: DEADBEEF expected exactly two cycles later
      issue(0, 1'b0, 4'h0, 32'h0000_1000, 32'h0, acc[0], w[0]);
      chk("rd_no_stall", w[0], 0);
      idle(4);

      // Single write: byte enables and data forwarded, response data is zero
      req[0] = 1; wr[0] = 1; wstrb[0] = 4'b0011; addr[0] = 32'h0000_1004; wdata[0] = 32'h1234_5678;
      @(negedge clk);
      chk("wr_sram_en", sram_en[0], 1);
      chk("wr_sram_wen", sram_wen[0], 4'b0011);
      chk("wr_sram_addr", sram_addr[0], 32'h0000_1004);
      chk("wr_sram_wdata", sram_wdata[0], 32'h1234_5678);
      @(posedge clk); #1;
      req[0] = 0;
      idle(4);

      // Six held reads on DEPTH=4, DELAY=3: full after four, reopen after first pop
      for (int i = 0; i < 6; i++)
         issue(1, 1'b0, 4'h0, 32'h0000_2000 + 32'(i * 4), 32'h0, acc[i], w[i]);
      chk("full_first4", acc[3], acc[0] + 3);
      chk("full_stall_cycles", w[4], 2);
      chk("full_5th_accept", acc[4], acc[0] + 6);
      chk("full_6th_accept", acc[5], acc[0] + 7);
      idle(12);

      // Random back-to-back traffic with occasional gaps on both instances
      for (int n = 0; n < 2; n++) begin
         for (int i = 0; i < 20; i++) begin
            issue(n, 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)),
                  $urandom & 32'hFFFF_FFFC, $urandom, t, k);
            if ($urandom_range(0, 3) == 0) idle(1);
         end
         idle(10);
      end

      // Asynchronous reset with two reads outstanding and a third being presented
      issue(0, 1'b0, 4'h0, 32'h0000_3000, 32'h0, t, k);
      issue(0, 1'b0, 4'h0, 32'h0000_3004, 32'h0, t, k);
      req[0] = 1; wr[0] = 0; addr[0] = 32'h0000_3008;
      #2 resetn = 1'b0;
      #1;
      chk("arst_addr_ok", addr_ok[0], 1);
      chk("arst_data_ok", data_ok[0], 0);
      chk("arst_rdata", rdata[0], 0);
      chk("arst_sram_en", sram_en[0], 0);
      chk("arst_sram_wen", sram_wen[0], 0);
      req[0] = 0;
      @(posedge clk); @(posedge clk);
      #3 resetn = 1'b1;
      idle(6);
      issue(0, 1'b0, 4'h0, 32'h0000_1000, 32'h0, t, k);
      chk("post_rst_no_stall", k, 0);
      idle(4);

      // Fifty back-to-back reads, DELAY=0: one accept per cycle, pointers wrap
      for (int i = 0; i < 50; i++) begin
         issue(0, 1'b0, 4'h0, 32'h0001_0000 + 32'(i * 4), 32'h0, t, k);
         chk("b2b_no_stall", k, 0);
      end

      k = 0;
      while ((u[0].outstanding != 0 || u[1].outstanding != 0) && k < 100) begin
         @(negedge clk);
         k++;
      end
      chk("drain", u[0].outstanding + u[1].outstanding, 0);
      idle(3);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/sram_like_responder.md
Name: sram_like_responder

Overview:
- Target (slave) end of the sram-like handshake our CPU core drives on its instruction and data ports: req/wr/size/wstrb/addr/wdata in, addr_ok/data_ok/rdata out.
- Accepts up to DEPTH outstanding requests and issues each one to a plain single-cycle synchronous SRAM port.
- Returns responses strictly in order, with a programmable extra delay, so the pipeline's split address/data handshakes can be exercised and run on block RAM.

Parameters:
DEPTH, 4, max outstanding requests including the in-flight SRAM read stage (power of two, 2..16)
DELAY, 0, extra cycles a captured response waits before data_ok (0..15)

Ports:
clk  input  1  clock, all state on rising edge
resetn  input  1  asynchronous active-low reset
req  input  1  master request valid
wr  input  1  1 = write, 0 = read
size  input  2  access size (00 byte, 01 half, 10 word); informational only
wstrb  input  4  write byte enables
addr  input  32  byte address
wdata  input  32  write data
addr_ok  output  1  request accepted this cycle when req && addr_ok
data_ok  output  1  response valid, one cycle per request
rdata  output  32  read data, valid with data_ok
sram_en  output  1  SRAM access enable
sram_wen  output  4  SRAM byte write enables
sram_addr  output  32  SRAM byte address, passed through unmodified
sram_wdata  output  32  SRAM write data
sram_rdata  input  32  SRAM read data, valid the cycle after sram_en

Behaviour:
- Clock is clk; reset is resetn, asynchronous, active-low.
- Reset clears count, FIFO pointers, in-flight flag and all timers. Reset values: addr_ok=1, data_ok=0, rdata=0, sram_en=0, sram_wen=0.
- Occupancy:
  - count = valid FIFO entries + in-flight flag.
  - addr_ok = (count < DEPTH). It is a function of registered state only and does not depend on a same-cycle pop.
- Accept (cycle T, req && addr_ok):
  - sram_en=1 combinationally in T.
  - sram_wen = wr ? wstrb : 4'b0.
  - sram_addr = addr; sram_wdata = wdata.
  - The in-flight flag is set at the end of T.
  - When no request is accepted: sram_en=0 and sram_wen=0.
- Capture (cycle T+1):
  - sram_rdata is pushed into the FIFO at the tail with timer=DELAY. For writes, 32'h0 is pushed instead.
  - The in-flight flag clears unless a new accept occurs in the same cycle.
- Timers: each valid entry's timer decrements by 1 per cycle while nonzero.
- Response:
  - data_ok = head valid && head timer==0. It is combinational from registered head state.
  - rdata = head data when data_ok, else 0.
  - The head pops at the end of that cycle.
  - Earliest data_ok is cycle T+2+DELAY.
  - The master never back-pressures data_ok.
- Ordering: responses leave strictly in acceptance order; at most one data_ok per cycle.
- Count arithmetic:
  - +1 on accept, -1 on pop, unchanged when both happen in one cycle.
  - Never exceeds DEPTH.
  - FIFO pointers wrap modulo DEPTH.
- Full: addr_ok=0. A held req is stalled with no SRAM access until count < DEPTH, which first occurs the cycle after a pop.
- Empty: data_ok=0, rdata=0.
- The back-to-back accept rate is one per cycle while not full.
- size is ignored. No alignment check; reads always return the full word.
- Reset mid-operation: all outstanding requests are dropped silently; no data_ok is produced for them.

Test Plan:
- DELAY=0, read addr 0x0000_1000 accepted at T, sram_rdata=0xDEADBEEF in T+1 -> sram_en=1, sram_wen=0 at T; data_ok=1, rdata=0xDEADBEEF at T+2 only.
- Write wr=1, wstrb=4'b0011, addr 0x1004, wdata 0x12345678 at T -> sram_en=1, sram_wen=0011, sram_addr=0x1004, sram_wdata=0x12345678 at T; data_ok=1, rdata=0 at T+2.
- DEPTH=4, DELAY=3, req held for 6 reads with sram_rdata=address -> addr_ok low after 4 accepts; first data_ok at T+5; addr_ok high the cycle after; all 6 responses in order, count never >4.
- DELAY=0, count=3 of 4, accept coinciding with a pop -> count stays 3, addr_ok stays 1, no response lost or duplicated over 20 random back-to-back requests vs. a scoreboard.
- Two reads outstanding, resetn pulsed low mid-cycle (asynchronous) -> outputs immediately at reset values, no data_ok after release, next read returns correct data at T+2.
- DELAY=0, reads every cycle for 50 cycles -> one accept per cycle, data_ok continuous from cycle 2, wrap-around of pointers verified.
